// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl
// Moves each load/store from the execute-stage LSU onto a word-wide data bus.
// Only one access is in flight at a time.
// - Store data is placed on the correct byte lanes with byte enables.
// - Load data comes back right-justified, with the bytes above the access
//   size forced to zero.
// - An access that crosses a word boundary needs two bus beats.
//
// Ports
//   s_clk_i, s_reset_i          clock, asynchronous active-high reset
//   s_req_i / s_ready_o         core request handshake
//   s_we_i, s_addr_i, s_size_i  access attributes
//   s_wdata_i                   right-justified store data
//   s_rvalid_o                  one-cycle completion pulse
//   s_rdata_o, s_err_o          valid with s_rvalid_o
//   s_bus_req_o / s_bus_gnt_i   bus address phase
//   s_bus_we_o, s_bus_addr_o    word-aligned bus address
//   s_bus_be_o, s_bus_wdata_o   byte enables and lane-positioned data
//   s_bus_rvalid_i              bus data-phase response
//   s_bus_rdata_i, s_bus_err_i  read data and error, valid with rvalid
//
// Parameter
//   BUS_TIMEOUT  number of response cycles to wait before the access is
//                aborted with an error; 0 disables the timeout.
//
// Build option
//   LSU_SPLIT_EN  When defined, misaligned accesses are split into two beats.
//                 When undefined, a misaligned access faults immediately and
//                 never reaches the bus.
module lsu_bus_ctrl #(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        s_clk_i,
  input  logic        s_reset_i,
  input  logic        s_req_i,
  output logic        s_ready_o,
  input  logic        s_we_i,
  input  logic [31:0] s_addr_i,
  input  logic [1:0]  s_size_i,
  input  logic [31:0] s_wdata_i,
  output logic        s_rvalid_o,
  output logic [31:0] s_rdata_o,
  output logic        s_err_o,
  output logic        s_bus_req_o,
  input  logic        s_bus_gnt_i,
  output logic        s_bus_we_o,
  output logic [31:0] s_bus_addr_o,
  output logic [3:0]  s_bus_be_o,
  output logic [31:0] s_bus_wdata_o,
  input  logic        s_bus_rvalid_i,
  input  logic [31:0] s_bus_rdata_i,
  input  logic        s_bus_err_i
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_REQ1, ST_WAIT1, ST_REQ2, ST_WAIT2, ST_RESP
  } state_e;

  localparam int unsigned CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
  // The counter holds 0..BUS_TIMEOUT-1. When a silent cycle arrives with the
  // counter at its last value, that is the expiry cycle.
  localparam logic [CW-1:0] TO_LAST = (BUS_TIMEOUT > 0) ? CW'(BUS_TIMEOUT - 1) : '0;

  state_e        state_q;
  logic          ready_q, rvalid_q, err_q;
  logic [31:0]   rdata_q;
  logic          bus_req_q, bus_we_q;
  logic [31:0]   bus_addr_q, bus_wdata_q;
  logic [3:0]    bus_be_q;
  logic          we_q;
  logic [1:0]    off_q, size_q;
  logic [CW-1:0] cnt_q;

  // Byte-lane mask over the two consecutive words touched by the request.
  logic [7:0] size_mask, m8;
  logic       split_in, reject_in, timeout_hit;

  always_comb begin
    size_mask = 8'h00;
    case (s_size_i)
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'h00;
    endcase
  end

  assign m8          = size_mask << s_addr_i[1:0];
  assign split_in    = |m8[7:4];
  assign timeout_hit = (BUS_TIMEOUT > 0) && (cnt_q == TO_LAST);

`ifdef LSU_SPLIT_EN
  logic          split_q;
  logic [3:0]    be2_q;
  logic [31:0]   wdata2_q, lo_q;
  logic [63:0]   w64;
  assign w64       = {32'b0, s_wdata_i} << {s_addr_i[1:0], 3'b000};
  assign reject_in = (s_size_i == 2'b11);
`else
  logic [31:0]   w64;
  assign w64       = s_wdata_i << {s_addr_i[1:0], 3'b000};
  assign reject_in = (s_size_i == 2'b11) || split_in;
`endif

  // Move the requested bytes down to bit 0. Bytes above the access size are
  // cleared.
  function automatic logic [31:0] align_load(input logic [63:0] pair,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size);
    logic [31:0] r;
    r = 32'(pair >> {off, 3'b000});
    case (size)
      2'b00:   return {24'b0, r[7:0]};
      2'b01:   return {16'b0, r[15:0]};
      default: return r;
    endcase
  endfunction

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      we_q        <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
`ifdef LSU_SPLIT_EN
      split_q     <= 1'b0;
      be2_q       <= '0;
      wdata2_q    <= '0;
      lo_q        <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s_req_i) begin
            ready_q <= 1'b0;
            we_q    <= s_we_i;
            off_q   <= s_addr_i[1:0];
            size_q  <= s_size_i;
            if (reject_in) begin
              // A request that can never reach the bus is answered at once.
              state_q  <= ST_RESP;
              rvalid_q <= 1'b1;
              err_q    <= 1'b1;
              rdata_q  <= '0;
            end else begin
              state_q     <= ST_REQ1;
              bus_req_q   <= 1'b1;
              bus_we_q    <= s_we_i;
              bus_addr_q  <= {s_addr_i[31:2], 2'b00};
              bus_be_q    <= m8[3:0];
              bus_wdata_q <= w64[31:0];
`ifdef LSU_SPLIT_EN
              split_q     <= split_in;
              be2_q       <= m8[7:4];
              wdata2_q    <= w64[63:32];
`endif
            end
          end
        end
        ST_REQ1: begin
          if (s_bus_gnt_i) begin
            state_q   <= ST_WAIT1;
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
          end
        end
        ST_WAIT1: begin
          if (s_bus_rvalid_i) begin
`ifdef LSU_SPLIT_EN
            lo_q <= s_bus_rdata_i;
            if (!s_bus_err_i && split_q) begin
              // The address wraps naturally from 0xFFFFFFFC to 0.
              state_q     <= ST_REQ2;
              bus_req_q   <= 1'b1;
              bus_addr_q  <= bus_addr_q + 32'd4;
              bus_be_q    <= be2_q;
              bus_wdata_q <= wdata2_q;
            end else
`endif
            begin
              state_q  <= ST_RESP;
              rvalid_q <= 1'b1;
              err_q    <= s_bus_err_i;
              rdata_q  <= (s_bus_err_i || we_q) ? '0
                        : align_load({32'b0, s_bus_rdata_i}, off_q, size_q);
            end
          end else if (timeout_hit) begin
            state_q  <= ST_RESP;
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= '0;
          end else if (BUS_TIMEOUT > 0) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef LSU_SPLIT_EN
        ST_REQ2: begin
          if (s_bus_gnt_i) begin
            state_q   <= ST_WAIT2;
            bus_req_q <= 1'b0;
            cnt_q     <= '0;
          end
        end
        ST_WAIT2: begin
          if (s_bus_rvalid_i) begin
            // An error on beat 2 does not undo the store bytes written by
            // beat 1.
            state_q  <= ST_RESP;
            rvalid_q <= 1'b1;
            err_q    <= s_bus_err_i;
            rdata_q  <= (s_bus_err_i || we_q) ? '0
                      : align_load({s_bus_rdata_i, lo_q}, off_q, size_q);
          end else if (timeout_hit) begin
            state_q  <= ST_RESP;
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= '0;
          end else if (BUS_TIMEOUT > 0) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`endif
        ST_RESP: begin
          state_q  <= ST_IDLE;
          ready_q  <= 1'b1;
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          rdata_q  <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign s_ready_o     = ready_q;
  assign s_rvalid_o    = rvalid_q;
  assign s_rdata_o     = rdata_q;
  assign s_err_o       = err_q;
  assign s_bus_req_o   = bus_req_q;
  assign s_bus_we_o    = bus_we_q;
  assign s_bus_addr_o  = bus_addr_q;
  assign s_bus_be_o    = bus_be_q;
  assign s_bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Testbench for lsu_bus_ctrl.
// - Runs directed accesses from the test plan, then randomized accesses.
// - A responsive bus model answers requests with random grant and response
//   delays.
// - Expected beats and load data are rebuilt byte by byte from the access
//   rules.
module tb_lsu_bus_ctrl;
  localparam int TO = 16;
`ifdef LSU_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic        s_clk_i = 1'b0;
  logic        s_reset_i;
  logic        s_req_i, s_we_i;
  logic [31:0] s_addr_i, s_wdata_i;
  logic [1:0]  s_size_i;
  logic        s_ready_o, s_rvalid_o, s_err_o;
  logic [31:0] s_rdata_o;
  logic        s_bus_req_o, s_bus_gnt_i, s_bus_we_o;
  logic [31:0] s_bus_addr_o, s_bus_wdata_o, s_bus_rdata_i;
  logic [3:0]  s_bus_be_o;
  logic        s_bus_rvalid_i, s_bus_err_i;

  lsu_bus_ctrl #(.BUS_TIMEOUT(TO)) dut (
    .s_clk_i(s_clk_i), .s_reset_i(s_reset_i), .s_req_i(s_req_i), .s_ready_o(s_ready_o),
    .s_we_i(s_we_i), .s_addr_i(s_addr_i), .s_size_i(s_size_i), .s_wdata_i(s_wdata_i),
    .s_rvalid_o(s_rvalid_o), .s_rdata_o(s_rdata_o), .s_err_o(s_err_o),
    .s_bus_req_o(s_bus_req_o), .s_bus_gnt_i(s_bus_gnt_i), .s_bus_we_o(s_bus_we_o),
    .s_bus_addr_o(s_bus_addr_o), .s_bus_be_o(s_bus_be_o), .s_bus_wdata_o(s_bus_wdata_o),
    .s_bus_rvalid_i(s_bus_rvalid_i), .s_bus_rdata_i(s_bus_rdata_i), .s_bus_err_i(s_bus_err_i)
  );

  always #5 s_clk_i = ~s_clk_i;

  int checks = 0;
  int failures = 0;

  // Observations from the most recent access.
  logic [31:0] b_addr[2];
  logic [31:0] b_wd[2];
  logic [3:0]  b_be[2];
  logic        b_we[2];
  logic [31:0] rsp[2];
  int          nbeats, gnt_cyc, last_rv_cyc, done_cyc;
  logic [31:0] o_rdata;
  logic        o_err;
  bit          done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_access(input bit we, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wdata, input int err_beat, input int gdly,
                            input int rdly, input bit no_rv,
                            input logic [31:0] rd0, input logic [31:0] rd1);
    int phase, cnt, n, off, exp_beats, exp_cyc;
    bit rsv, spl, exp_err, fresh;
    logic [31:0] exp_addr, exp_wd, exp_rd;
    logic [3:0]  exp_be;

    chk("ready_before", s_ready_o, 1);
    s_req_i = 1'b1; s_we_i = we; s_addr_i = addr; s_size_i = size; s_wdata_i = wdata;
    @(negedge s_clk_i);
    // Scramble the request inputs so that any late sampling shows up.
    s_req_i = 1'b0; s_addr_i = $urandom; s_wdata_i = $urandom;
    s_size_i = 2'($urandom); s_we_i = 1'($urandom);

    nbeats = 0; done = 0; phase = 0; cnt = 0;
    gnt_cyc = -1; last_rv_cyc = -1; done_cyc = -1;
    for (int c = 1; c <= 200; c++) begin
      s_bus_gnt_i = 1'b0; s_bus_rvalid_i = 1'b0; s_bus_err_i = 1'b0; s_bus_rdata_i = $urandom;
      fresh = 0;
      if (s_rvalid_o) begin
        done = 1; done_cyc = c; o_rdata = s_rdata_o; o_err = s_err_o;
        break;
      end
      if (phase == 0 && s_bus_req_o) begin
        if (nbeats < 2) begin
          b_addr[nbeats] = s_bus_addr_o; b_be[nbeats] = s_bus_be_o;
          b_wd[nbeats] = s_bus_wdata_o; b_we[nbeats] = s_bus_we_o;
        end
        nbeats++; phase = 1; cnt = gdly; fresh = 1;
      end
      if (phase == 1) begin
        if (!fresh && nbeats <= 2) begin
          chk("req_hold", {s_bus_req_o, s_bus_be_o}, {1'b1, b_be[nbeats-1]});
          chk("addr_hold", s_bus_addr_o, b_addr[nbeats-1]);
        end
        if (cnt == 0) begin
          s_bus_gnt_i = 1'b1; phase = 2; cnt = rdly; gnt_cyc = c;
        end else cnt--;
      end else if (phase == 2) begin
        chk("req_drop", s_bus_req_o, 0);
        if (!no_rv) begin
          if (cnt == 0) begin
            s_bus_rvalid_i = 1'b1;
            s_bus_rdata_i = (nbeats == 1) ? rd0 : rd1;
            s_bus_err_i = (nbeats == err_beat);
            if (nbeats <= 2) rsp[nbeats-1] = s_bus_rdata_i;
            last_rv_cyc = c; phase = 0;
          end else cnt--;
        end
      end
      @(negedge s_clk_i);
    end
    s_bus_gnt_i = 1'b0; s_bus_rvalid_i = 1'b0; s_bus_err_i = 1'b0;
    chk("done", done, 1);
    if (!done) begin
      s_reset_i = 1'b1; @(negedge s_clk_i); s_reset_i = 1'b0; @(negedge s_clk_i);
      return;
    end

    // Reference model built from the access rules.
    n   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    off = int'(addr[1:0]);
    rsv = (size == 2'b11);
    spl = !rsv && (off + n > 4);
    if (rsv || (spl && !SPLIT_EN)) begin
      exp_beats = 0; exp_err = 1; exp_cyc = 1;
    end else if (no_rv) begin
      exp_beats = 1; exp_err = 1; exp_cyc = gnt_cyc + 1 + TO;
    end else if (err_beat == 1) begin
      exp_beats = 1; exp_err = 1; exp_cyc = last_rv_cyc + 1;
    end else begin
      exp_beats = spl ? 2 : 1; exp_err = spl && (err_beat == 2); exp_cyc = last_rv_cyc + 1;
    end
    chk("beats", nbeats, exp_beats);
    for (int k = 0; k < 2; k++) begin
      if (k < nbeats && k < exp_beats) begin
        exp_addr = {addr[31:2], 2'b00} + 32'(4 * k);
        exp_be = '0; exp_wd = '0;
        for (int l = 0; l < 4; l++) begin
          int j;
          j = 4 * k + l - off;
          if (j >= 0 && j < n) exp_be[l] = 1'b1;
          if (j >= 0 && j < 4) exp_wd[8*l +: 8] = wdata[8*j +: 8];
        end
        chk("beat_addr", b_addr[k], exp_addr);
        chk("beat_be", {28'b0, b_be[k]}, {28'b0, exp_be});
        chk("beat_we", b_we[k], we);
        if (we) chk("beat_wdata", b_wd[k], exp_wd);
      end
    end
    exp_rd = '0;
    if (!we && !exp_err)
      for (int i = 0; i < n; i++) begin
        int p;
        p = off + i;
        exp_rd[8*i +: 8] = rsp[p / 4][8*(p % 4) +: 8];
      end
    chk("done_cycle", done_cyc, exp_cyc);
    chk("err", o_err, exp_err);
    chk("rdata", o_rdata, exp_rd);
    @(negedge s_clk_i);
    chk("pulse_one", s_rvalid_o, 0);
    chk("ready_after", s_ready_o, 1);
    $display("access we=%0d addr=%h size=%0d beats=%0d err=%0d rdata=%h cyc=%0d",
             we, addr, size, nbeats, o_err, o_rdata, done_cyc);
  endtask

  initial begin
    s_reset_i = 1'b1; s_req_i = 0; s_we_i = 0; s_addr_i = 0; s_size_i = 0; s_wdata_i = 0;
    s_bus_gnt_i = 0; s_bus_rvalid_i = 0; s_bus_rdata_i = 0; s_bus_err_i = 0;
    @(negedge s_clk_i); @(negedge s_clk_i);
    chk("rst_ready", s_ready_o, 1);
    chk("rst_outs", {s_rvalid_o, s_err_o, s_bus_req_o, s_bus_we_o, s_bus_be_o}, 0);
    chk("rst_data", s_rdata_o | s_bus_addr_o | s_bus_wdata_o, 0);
    s_reset_i = 1'b0;
    @(negedge s_clk_i);

    // lw 0x100, single beat, fastest bus
    run_access(0, 32'h100, 2'b10, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0);
    chk("lw_rdata", o_rdata, 32'hDEADBEEF);
    chk("lw_cycle", done_cyc, 3);
    chk("lw_be", b_be[0], 4'b1111);
    // lb 0x101
    run_access(0, 32'h101, 2'b00, 0, 0, 0, 0, 0, 32'h0000AB00, 0);
    chk("lb_rdata", o_rdata, 32'h000000AB);
    chk("lb_be", b_be[0], 4'b0010);
`ifdef LSU_SPLIT_EN
    run_access(0, 32'h103, 2'b01, 0, 0, 0, 0, 0, 32'hAABBCCDD, 32'h11223344);
    chk("lh_split_rdata", o_rdata, 32'h000044AA);
    run_access(1, 32'h102, 2'b10, 32'h12345678, 0, 0, 0, 0, 0, 0);
    chk("sw_split_wd1", b_wd[0], 32'h56780000);
    chk("sw_split_wd2", b_wd[1], 32'h00001234);
    run_access(0, 32'h101, 2'b10, 0, 1, 1, 1, 0, 32'h55555555, 0);
    chk("err_beat1_beats", nbeats, 1);
    run_access(0, 32'hFFFFFFFE, 2'b10, 0, 0, 0, 0, 0, 32'h01020304, 32'h05060708);
    chk("wrap_addr2", b_addr[1], 32'h0);
`else
    run_access(0, 32'h101, 2'b10, 0, 0, 0, 0, 0, 32'h55555555, 0);
    chk("misalign_cycle", done_cyc, 1);
    chk("misalign_err", o_err, 1);
`endif
    // Timeout: grant given, response never comes.
    run_access(0, 32'h200, 2'b10, 0, 0, 0, 0, 1, 0, 0);
    chk("timeout_cycle", done_cyc, 1 + 1 + TO);
    // Reserved size
    run_access(0, 32'h300, 2'b11, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of an access, then a stray response in IDLE.
    s_req_i = 1; s_we_i = 0; s_addr_i = 32'h400; s_size_i = 2'b10;
    @(negedge s_clk_i);
    s_req_i = 0;
    chk("midrst_req", s_bus_req_o, 1);
    s_reset_i = 1'b1; #1;
    chk("midrst_state", {s_ready_o, s_bus_req_o, s_rvalid_o}, 3'b100);
    @(negedge s_clk_i);
    s_reset_i = 1'b0; s_bus_rvalid_i = 1'b1; s_bus_rdata_i = 32'hCAFEF00D;
    @(negedge s_clk_i);
    s_bus_rvalid_i = 1'b0;
    chk("stray_rvalid", {s_rvalid_o, s_ready_o, s_bus_req_o}, 3'b010);
    $display("reset mid-access and stray response done");

    // Randomized accesses
    for (int t = 0; t < 80; t++) begin
      logic [1:0] sz;
      int eb;
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_access(1'($urandom), $urandom, sz, $urandom, eb,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 19) == 0), $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
Sequences every load/store between the execute-stage LSU and the data bus. Issues word-aligned bus transfers with byte enables and splits misaligned accesses into two beats. Right-justifies and merges the returned load data, so the downstream load sign/zero-extension decoder always runs with alignment 2'b00. Keeps one access in flight at a time.

Parameters:
BUS_TIMEOUT, 16, cycles to wait for s_bus_rvalid_i after grant before aborting with error; 0 disables the timeout.

Ports:
s_clk_i  input  1  clock
s_reset_i  input  1  asynchronous active-high reset
s_req_i  input  1  core access request
s_ready_o  output  1  request accepted when s_req_i & s_ready_o
s_we_i  input  1  1 = store
s_addr_i  input  32  byte address
s_size_i  input  2  00 byte, 01 half, 10 word, 11 reserved
s_wdata_i  input  32  right-justified store data
s_rvalid_o  output  1  one-cycle completion pulse (loads and stores)
s_rdata_o  output  32  right-justified load data, upper bytes zero
s_err_o  output  1  valid with s_rvalid_o; access faulted
s_bus_req_o  output  1  bus address-phase request
s_bus_gnt_i  input  1  address phase accepted
s_bus_we_o  output  1  bus write
s_bus_addr_o  output  32  word-aligned address, [1:0]=00
s_bus_be_o  output  4  byte enables
s_bus_wdata_o  output  32  lane-positioned write data
s_bus_rvalid_i  input  1  data-phase response
s_bus_rdata_i  input  32  read data
s_bus_err_i  input  1  error response, valid with s_bus_rvalid_i

Behaviour:
- Reset: state IDLE; s_ready_o=1; all other outputs 0; timeout counter 0. Reset mid-access drops the access with no core response. Any late bus response arriving in IDLE is ignored.
- Accept: in IDLE, s_req_i=1 captures addr, size, we and wdata. Offset off = addr[1:0]. Byte count n = 1, 2 or 4.
- Masks: m8 = ((1<<n)-1) << off, 8 bits. split = |m8[7:4].
  - Store lanes: w64 = {32'b0, wdata} << (8*off).
  - Beat 1: addr&~3, be m8[3:0], wdata w64[31:0].
  - Beat 2: (addr&~3)+4 (32-bit wrap from 0xFFFFFFFC to 0), be m8[7:4], wdata w64[63:32].
- Size 11: no bus access. Go directly to RESP with err=1.
- States:
  - IDLE -> REQ1 on accept.
  - REQ1: bus_req=1, outputs held stable until gnt -> WAIT1.
  - WAIT1: on rvalid, latch rdata into lo. If err or !split -> RESP; else -> REQ2.
  - REQ2 / WAIT2: same as REQ1/WAIT1 for beat 2; rdata latched into hi; then -> RESP.
  - RESP: s_rvalid_o=1 for exactly one cycle -> IDLE.
- s_ready_o=1 only in IDLE, so the next access is accepted no earlier than the cycle after the RESP pulse.
- Load data:
  - s_rdata_o = ({hi, lo} >> (8*off))[31:0], with bytes above n forced to 0.
  - s_rdata_o = 0 for stores or on error.
- Latency: accept at cycle 0, s_bus_req_o at cycle 1. Single beat with gnt at cycle 1 and rvalid at cycle 2 gives s_rvalid_o at cycle 3. Split access adds two cycles minimum.
- Error on beat 1: beat 2 is never issued; err=1. Error on beat 2: err=1; beat 1 store bytes remain written, no rollback.
- s_bus_rvalid_i outside WAIT1/WAIT2, and s_bus_gnt_i while s_bus_req_o=0, are ignored.
- Timeout (BUS_TIMEOUT>0):
  - Counter clears on entry to WAIT1/WAIT2 and increments each cycle without rvalid.
  - When it reaches BUS_TIMEOUT -> RESP with err=1.
  - rvalid in the same cycle as expiry wins.

Optional Feature:
LSU_SPLIT_EN
- Defined: misaligned accesses are split as above.
- Undefined: accesses with split=1 issue no bus transfer and go IDLE->RESP with s_err_o=1, reported as a misaligned exception. State REQ2/WAIT2 logic and the hi register are not built.

Test Plan:
- lw 0x100, gnt at cycle 1, rdata 0xDEADBEEF at cycle 2 -> one beat, addr 0x100, be 1111; s_rvalid_o at cycle 3, s_rdata_o 0xDEADBEEF, err 0.
- lb 0x101, rdata 0x0000AB00 -> be 0010, s_rdata_o 0x000000AB.
- lh 0x103 (LSU_SPLIT_EN) -> beat 1: 0x100, be 1000, rdata 0xAABBCCDD; beat 2: 0x104, be 0001, rdata 0x11223344; s_rdata_o 0x000044AA.
- sw 0x12345678 at 0x102 -> beat 1: 0x100, be 1100, wdata 0x56780000; beat 2: 0x104, be 0011, wdata 0x00001234; s_rvalid_o=1, err 0.
- Split lw 0x101 with s_bus_err_i on beat 1 -> no second s_bus_req_o; s_err_o=1, s_rdata_o 0.
- BUS_TIMEOUT=16, grant given, no rvalid -> s_rvalid_o=1 with s_err_o=1 exactly 16 cycles after entering WAIT1. Without LSU_SPLIT_EN, lw 0x101 -> no bus request, error response in the cycle after accept.
